uart_rx: RTL

- 8N1 asynchronous serial receiver; it is the receiving end of the serial link whose transmit side is timed by the team's baud clock divider.
- Generates its own 16x-oversampling tick from the system clock and validates the start bit at mid-bit.
- Samples each data bit at its centre and checks the stop bit.
- Presents each received byte on a valid/ready interface to downstream logic, such as a command parser or FIFO.

---
 rtl/uart_rx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver with 16x oversampling; the byte appears one clk after the mid-stop sample.
// A held byte blocks delivery until rx_ready; a byte completing meanwhile is dropped with an overrun pulse.
module uart_rx #(
  parameter int IN_FREQ  = 50000000,
  parameter int OUT_FREQ = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int DIV = IN_FREQ / (OUT_FREQ * 16);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if (DIV < 1) begin : g_div_check
      $error("uart_rx: IN_FREQ/(OUT_FREQ*16) must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]    tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  logic rx_s, tick, smp_start, smp_bit, smp_stop, deliver;

  assign rx_s = sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (smp_start) state_d = rx_s ? IDLE : DATA;
      DATA:    if (smp_bit && bit_idx_q == 3'd7) state_d = STOP;
      // Leaving at mid-stop lets a start bit right after a one-bit stop be caught.
      STOP:    if (smp_stop) state_d = rx_s ? IDLE : BRK;
      BRK:     if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    tick      = (state_q != IDLE) && (div_cnt_q == CW'(DIV - 1));
    smp_start = (state_q == START) && tick && (tick_cnt_q == 4'd7);
    smp_bit   = (state_q == DATA)  && tick && (tick_cnt_q == 4'd15);
    smp_stop  = (state_q == STOP)  && tick && (tick_cnt_q == 4'd15);
    deliver   = smp_stop && rx_s;
  end

  always_comb begin
    sync1_d     = rx;
    sync2_d     = sync1_q;
    div_cnt_d   = div_cnt_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = smp_stop && !rx_s;
    overrun_d   = 1'b0;

    // Counters sit at zero in IDLE so the first START clk is aligned to the start edge.
    if (state_q == IDLE) begin
      div_cnt_d  = '0;
      tick_cnt_d = '0;
      bit_idx_d  = '0;
    end else begin
      div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
      if (smp_start)  tick_cnt_d = '0;
      else if (tick)  tick_cnt_d = tick_cnt_q + 4'd1;
    end

    if (smp_bit) begin
      shift_d   = {rx_s, shift_q[7:1]};
      bit_idx_d = bit_idx_q + 3'd1;
    end

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      div_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      div_cnt_q   <= div_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
